// File: rtl/change_capture_if.sv
// Consumer-side port of change_capture: FWFT head record, valid/ready handshake, occupancy.
interface change_capture_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned TSW   = 16,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [TSW-1:0] out_ts;
    logic           out_ovf;
    logic [CW-1:0]  count;

    modport master (
        output out_valid, out_data, out_ts, out_ovf, count,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_ts, out_ovf, count,
        output out_ready
    );
endinterface

// File: rtl/change_capture.sv
// Probe change detector: timestamps each value change and queues {value, ts, ovf}
// records in a first-word-fall-through FIFO drained over valid/ready.
module change_capture #(
    parameter int unsigned W     = 8,
    parameter int unsigned TSW   = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [W-1:0]         probe,
    change_capture_if.master     rd
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = W + TSW + 1;

    localparam logic [0:0] DISARMED = 1'b0;
    localparam logic [0:0] ARMED    = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [W-1:0]   prev_q;
    logic [TSW-1:0] ts_q;
    logic           ovf_pend_q;
    logic [RW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           valid_q;

    logic change_c, pop_c, full_c, push_c, drop_c;

    // Arming FSM: the first enabled edge only takes a baseline, no event.
    always_comb begin
        state_d  = state_q;
        change_c = 1'b0;
        case (state_q)
            DISARMED: if (en) state_d = ARMED;
            ARMED: begin
                if (!en) state_d = DISARMED;
                else     change_c = (probe != prev_q);
            end
            default: state_d = DISARMED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= DISARMED;
        else     state_q <= state_d;
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop_c   = valid_q && rd.out_ready;
        full_c  = (count_q == CW'(DEPTH));
        push_c  = change_c && (!full_c || pop_c);
        drop_c  = change_c && full_c && !pop_c;
        count_d = count_q;
        if (push_c && !pop_c)      count_d = count_q + CW'(1);
        else if (pop_c && !push_c) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            ts_q       <= '0;
            ovf_pend_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            ts_q    <= ts_q + TSW'(1);
            count_q <= count_d;
            valid_q <= (count_d != '0);
            if (en) prev_q <= probe;
            if (push_c)      ovf_pend_q <= 1'b0;
            else if (drop_c) ovf_pend_q <= 1'b1;
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Record storage is cleared on reset so the head fields are never X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= {probe, ts_q, ovf_pend_q};
        end
    end

    assign rd.out_valid = valid_q;
    assign rd.count     = count_q;
    assign {rd.out_data, rd.out_ts, rd.out_ovf} = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_change_capture.sv
// Scoreboard bench for change_capture: reference model queues expected records,
// a negedge monitor compares the presented head and occupancy.
module tb_change_capture;
    localparam int unsigned W     = 8;
    localparam int unsigned TSW   = 4;
    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [W-1:0]   d;
        logic [TSW-1:0] ts;
        logic           ovf;
    } rec_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] probe;

    change_capture_if #(.W(W), .TSW(TSW), .DEPTH(DEPTH)) bus ();

    change_capture #(.W(W), .TSW(TSW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .probe (probe),
        .rd    (bus)
    );

    int checks   = 0;
    int failures = 0;

    rec_t         exp_q[$];
    int           m_cnt   = 0;
    int           m_cyc   = 0;
    logic         m_armed = 1'b0;
    logic [W-1:0] m_prev  = '0;
    logic         m_ovf   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference behaviour for one rising edge, given the inputs the DUT saw.
    task automatic model_edge(input logic e, input logic [W-1:0] p, input logic r);
        bit   pop;
        rec_t rec;
        pop = (m_cnt > 0) && r;
        if (!m_armed) begin
            if (e) begin
                m_armed = 1'b1;
                m_prev  = p;
            end
        end else if (!e) begin
            m_armed = 1'b0;
        end else begin
            if (p != m_prev) begin
                if (m_cnt < int'(DEPTH) || pop) begin
                    rec.d   = p;
                    rec.ts  = TSW'(m_cyc % (1 << TSW));
                    rec.ovf = m_ovf;
                    exp_q.push_back(rec);
                    m_ovf = 1'b0;
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            m_prev = p;
        end
        if (pop) m_cnt--;
        m_cyc++;
    endtask

    task automatic step(input logic e, input logic [W-1:0] p, input logic r);
        en            = e;
        probe         = p;
        bus.out_ready = r;
        @(posedge clk);
        if (!rst) model_edge(e, p, r);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt   = 0;
        m_cyc   = 0;
        m_armed = 1'b0;
        m_prev  = '0;
        m_ovf   = 1'b0;
    endtask

    // Monitor: occupancy and head record against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", longint'(bus.count), longint'(m_cnt));
            chk("out_valid", longint'(bus.out_valid), longint'(m_cnt > 0));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_record", 1, 0);
                end else begin
                    chk("head_record", longint'({bus.out_data, bus.out_ts, bus.out_ovf}),
                        longint'({exp_q[0].d, exp_q[0].ts, exp_q[0].ovf}));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        en            = 1'b0;
        probe         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", longint'(bus.out_valid), 0);
        chk("reset_count", longint'(bus.count), 0);
        rst = 1'b0;
        model_reset();

        // Baseline then a single change on the fifth edge.
        repeat (4) step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'hA5, 1'b0);
        chk("first_data", longint'(bus.out_data), 64'hA5);
        chk("first_ts", longint'(bus.out_ts), 4);
        chk("first_ovf", longint'(bus.out_ovf), 0);
        chk("first_count", longint'(bus.count), 1);
        step(1'b1, 8'hA5, 1'b1);

        // Overfill with the consumer stalled.
        for (int i = 1; i <= 10; i++) step(1'b1, W'(i), 1'b0);
        chk("full_count", longint'(bus.count), 8);
        step(1'b1, 8'h0B, 1'b1);
        chk("full_pushpop_count", longint'(bus.count), 8);
        step(1'b1, 8'h0C, 1'b1);
        chk("full_pushpop_count2", longint'(bus.count), 8);
        repeat (9) step(1'b1, 8'h0C, 1'b1);
        chk("drained_count", longint'(bus.count), 0);

        // Disable while the probe moves, then re-baseline.
        repeat (2) step(1'b1, 8'h11, 1'b1);
        repeat (3) step(1'b0, 8'h22, 1'b1);
        repeat (2) step(1'b1, 8'h22, 1'b1);
        chk("rebaseline_count", longint'(bus.count), 0);
        step(1'b1, 8'h33, 1'b1);
        chk("after_reenable_data", longint'(bus.out_data), 64'h33);
        chk("after_reenable_count", longint'(bus.count), 1);
        step(1'b1, 8'h33, 1'b1);

        // Mid-cycle asynchronous reset with records queued.
        step(1'b1, 8'h50, 1'b0);
        step(1'b1, 8'h51, 1'b0);
        step(1'b1, 8'h52, 1'b0);
        chk("pre_reset_count", longint'(bus.count), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", longint'(bus.out_valid), 0);
        chk("async_reset_count", longint'(bus.count), 0);
        model_reset();
        rst = 1'b0;
        step(1'b1, 8'h40, 1'b0);
        step(1'b1, 8'h41, 1'b0);
        chk("post_reset_ts", longint'(bus.out_ts), 1);
        chk("post_reset_data", longint'(bus.out_data), 64'h41);

        // Random traffic; timestamp wrap is frequent with the narrow counter.
        for (int i = 0; i < 2000; i++) begin
            logic         e;
            logic [W-1:0] p;
            logic         r;
            e = ($urandom_range(0, 15) != 0);
            p = ($urandom_range(0, 1) == 0) ? probe : W'($urandom_range(0, 7));
            r = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(e, p, r);
        end
        repeat (12) step(1'b0, probe, 1'b1);
        chk("final_count", longint'(bus.count), 0);
        chk("scoreboard_empty", longint'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
